// File: rtl/trigger_pkg.sv
// rtl/trigger_pkg.sv - shared constants and state encoding for trigger blocks
// Contents: FSM state enum, default line count / counter width, miss counter width.
package trigger_pkg;

  localparam int R_DEF  = 8;
  localparam int DW_DEF = 16;
  localparam int MISS_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } trig_state_e;

endpackage

// File: rtl/trigger_edge_det.sv
// rtl/trigger_edge_det.sv - registered rising-edge detector with async active-low reset
// Ports:
//   clk  - system clock
//   rstn - asynchronous active-low reset
//   din  - level input
//   rise - high when din is 1 and the previous sample was 0
module trigger_edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise
);

  logic hist;

  // History resets to 1 so a level already high at reset release is not
  // mistaken for a fresh edge; it must be seen low first.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist <= 1'b1;
    end else begin
      hist <= din;
    end
  end

  assign rise = din & ~hist;

endmodule

// File: rtl/trigger_output.sv
// rtl/trigger_output.sv - trigger pulse generator with programmable delay, width, holdoff and polarity
// Optional feature macro: TRIGGER_OUTPUT_MISS_CNT_EN (adds miss_clr input and miss_cnt output)
// Ports:
//   clk, rstn         - clock, asynchronous active-low reset
//   trig_req          - request; a rising edge seen in IDLE starts a sequence
//   trig_sel          - line enable mask (latched at accept)
//   trig_pol          - per-line idle level (live in IDLE, latched at accept)
//   delay/width/holdoff - sequence timing (latched at accept)
//   trig_out          - registered trigger lines
//   busy              - sequence in progress
//   done              - one-cycle tick in the last active cycle
//   miss_clr/miss_cnt - dropped-request counter (optional)
module trigger_output
  import trigger_pkg::*;
#(
  parameter int R  = R_DEF,
  parameter int DW = DW_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              trig_req,
  input  logic [R-1:0]      trig_sel,
  input  logic [R-1:0]      trig_pol,
  input  logic [DW-1:0]     delay,
  input  logic [DW-1:0]     width,
  input  logic [DW-1:0]     holdoff,
`ifdef TRIGGER_OUTPUT_MISS_CNT_EN
  input  logic              miss_clr,
  output logic [MISS_W-1:0] miss_cnt,
`endif
  output logic [R-1:0]      trig_out,
  output logic              busy,
  output logic              done
);

  localparam logic [DW-1:0] ONE = DW'(1);

  trig_state_e   state;
  trig_state_e   state_nxt;
  logic [DW-1:0] cnt;
  logic [DW-1:0] cnt_nxt;
  logic          rise;
  logic          accept;
  logic          last_pulse;

  logic [R-1:0]  sel_q;
  logic [R-1:0]  pol_q;
  logic [DW-1:0] dly_q;
  logic [DW-1:0] wid_q;
  logic [DW-1:0] hold_q;

  logic [DW-1:0] wid_eff;
  logic [R-1:0]  pol_eff;

  trigger_edge_det u_edge (
    .clk  (clk),
    .rstn (rstn),
    .din  (trig_req),
    .rise (rise)
  );

  // A programmed width of 0 still produces one active cycle.
  assign wid_eff = (width == '0) ? ONE : width;

  // Idle lines follow the live polarity so software sees level changes
  // without having to fire a trigger.
  assign pol_eff = (state == IDLE) ? trig_pol : pol_q;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    last_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          accept    = 1'b1;
          cnt_nxt   = '0;
          state_nxt = (delay == '0) ? PULSE : DELAY;
        end
      end
      DELAY: begin
        if (cnt == dly_q - ONE) begin
          cnt_nxt   = '0;
          state_nxt = PULSE;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      PULSE: begin
        if (cnt == wid_q - ONE) begin
          last_pulse = 1'b1;
          cnt_nxt    = '0;
          state_nxt  = (hold_q != '0) ? HOLD : IDLE;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      HOLD: begin
        if (cnt == hold_q - ONE) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_q  <= '0;
      pol_q  <= '0;
      dly_q  <= '0;
      wid_q  <= '0;
      hold_q <= '0;
    end else if (accept) begin
      sel_q  <= trig_sel;
      pol_q  <= trig_pol;
      dly_q  <= delay;
      wid_q  <= wid_eff;
      hold_q <= holdoff;
    end
  end

  // Outputs are one register stage behind the state, which places the first
  // active cycle at accept + delay + 1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      trig_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      trig_out <= pol_eff ^ ({R{state == PULSE}} & sel_q);
      busy     <= (state != IDLE);
      done     <= last_pulse;
    end
  end

`ifdef TRIGGER_OUTPUT_MISS_CNT_EN
  logic drop;

  assign drop = rise & (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      miss_cnt <= '0;
    end else if (miss_clr) begin
      miss_cnt <= '0;
    end else if (drop && (miss_cnt != '1)) begin
      miss_cnt <= miss_cnt + MISS_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_trigger_output.sv
// tb/tb_trigger_output.sv - directed self-checking bench for trigger_output
// Optional feature macro: TRIGGER_OUTPUT_MISS_CNT_EN (enables miss counter checks)
module tb_trigger_output;

  logic        clk;
  logic        rstn;
  logic        trig_req;
  logic [7:0]  trig_sel;
  logic [7:0]  trig_pol;
  logic [15:0] delay;
  logic [15:0] width;
  logic [15:0] holdoff;
  logic [7:0]  trig_out;
  logic        busy;
  logic        done;
`ifdef TRIGGER_OUTPUT_MISS_CNT_EN
  logic        miss_clr;
  logic [15:0] miss_cnt;
`endif

  int n_chk;
  int n_pass;

  trigger_output #(.R(8), .DW(16)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .trig_req (trig_req),
    .trig_sel (trig_sel),
    .trig_pol (trig_pol),
    .delay    (delay),
    .width    (width),
    .holdoff  (holdoff),
`ifdef TRIGGER_OUTPUT_MISS_CNT_EN
    .miss_clr (miss_clr),
    .miss_cnt (miss_cnt),
`endif
    .trig_out (trig_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; outputs seen here belong to that cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int cnt_done;
    int cnt_busy;
    logic [7:0] exp_out;

    n_chk    = 0;
    n_pass   = 0;
    rstn     = 1'b1;
    trig_req = 1'b0;
    trig_sel = 8'h00;
    trig_pol = 8'h00;
    delay    = 16'd0;
    width    = 16'd0;
    holdoff  = 16'd0;
`ifdef TRIGGER_OUTPUT_MISS_CNT_EN
    miss_clr = 1'b0;
`endif

    // Reset state
    #2 rstn = 1'b0;
    ticks(2);
    check("rst_trig_out", 32'(trig_out), 32'h0);
    check("rst_busy",     32'(busy),     32'h0);
    check("rst_done",     32'(done),     32'h0);
    rstn = 1'b1;
    ticks(2);

    // Idle lines follow live polarity
    trig_pol = 8'hA5;
    ticks(2);
    check("idle_live_pol", 32'(trig_out), 32'hA5);
    trig_pol = 8'h00;
    ticks(2);

    // Basic: delay 0, width 4, holdoff 0
    trig_sel = 8'h05;
    delay    = 16'd0;
    width    = 16'd4;
    holdoff  = 16'd0;
    trig_req = 1'b1;
    tick();
    trig_req = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("basic_out_%0d", k),  32'(trig_out), 32'h05);
      check($sformatf("basic_busy_%0d", k), 32'(busy),     32'h1);
      check($sformatf("basic_done_%0d", k), 32'(done),     (k == 4) ? 32'h1 : 32'h0);
    end
    tick();
    check("basic_out_after",  32'(trig_out), 32'h00);
    check("basic_busy_after", 32'(busy),     32'h0);
    check("basic_done_after", 32'(done),     32'h0);

    // Delay and polarity: delay 3, width 2, pol FF, sel 01; pol flipped mid-sequence
    trig_pol = 8'hFF;
    trig_sel = 8'h01;
    delay    = 16'd3;
    width    = 16'd2;
    ticks(2);
    check("dly_idle_out", 32'(trig_out), 32'hFF);
    trig_req = 1'b1;
    tick();
    trig_req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 2) trig_pol = 8'h00;
      exp_out = (k == 4 || k == 5) ? 8'hFE : 8'hFF;
      if (k == 6) exp_out = 8'h00;
      check($sformatf("dly_out_%0d", k),  32'(trig_out), 32'(exp_out));
      check($sformatf("dly_done_%0d", k), 32'(done),     (k == 5) ? 32'h1 : 32'h0);
      check($sformatf("dly_busy_%0d", k), 32'(busy),     (k <= 5) ? 32'h1 : 32'h0);
    end

    // Width 0 with holdoff 5; edge at 4 dropped, edge at 7 accepted
    trig_pol = 8'h00;
    trig_sel = 8'h0F;
    delay    = 16'd0;
    width    = 16'd0;
    holdoff  = 16'd5;
    tick();
    trig_req = 1'b1;
    tick();
    trig_req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 3) trig_req = 1'b1;
      if (k == 4) trig_req = 1'b0;
      if (k == 6) trig_req = 1'b1;
      if (k == 7) trig_req = 1'b0;
      check($sformatf("w0_out_%0d", k),  32'(trig_out), (k == 1 || k == 8) ? 32'h0F : 32'h00);
      check($sformatf("w0_done_%0d", k), 32'(done),     (k == 1 || k == 8) ? 32'h1 : 32'h0);
      check($sformatf("w0_busy_%0d", k), 32'(busy),     (k == 7) ? 32'h0 : 32'h1);
    end
    ticks(5);
    tick();
    check("w0_second_idle", 32'(busy), 32'h0);

    // Level hold: one sequence per 0->1 transition
    trig_sel = 8'h01;
    width    = 16'd2;
    holdoff  = 16'd0;
    trig_req = 1'b1;
    cnt_done = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (done) cnt_done++;
    end
    check("level_once", 32'(cnt_done), 32'd1);
    trig_req = 1'b0;
    tick();
    trig_req = 1'b1;
    cnt_done = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (done) cnt_done++;
    end
    check("level_refire", 32'(cnt_done), 32'd1);
    trig_req = 1'b0;
    ticks(3);

    // Reset during PULSE; request held high through release must not fire
    trig_sel = 8'hFF;
    width    = 16'd10;
    trig_req = 1'b1;
    tick();
    ticks(2);
    check("rstp_in_pulse", 32'(trig_out), 32'hFF);
    #2 rstn = 1'b0;
    #1;
    check("rstp_out_async",  32'(trig_out), 32'h00);
    check("rstp_busy_async", 32'(busy),     32'h0);
    check("rstp_done_async", 32'(done),     32'h0);
    ticks(2);
    rstn = 1'b1;
    cnt_done = 0;
    cnt_busy = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) cnt_done++;
      if (busy) cnt_busy++;
    end
    check("rstp_no_fire_busy", 32'(cnt_busy), 32'd0);
    check("rstp_no_fire_done", 32'(cnt_done), 32'd0);
    trig_req = 1'b0;
    tick();
    trig_req = 1'b1;
    tick();
    tick();
    check("rstp_fire_busy", 32'(busy),     32'h1);
    check("rstp_fire_out",  32'(trig_out), 32'hFF);
    trig_req = 1'b0;
    ticks(12);
    check("rstp_end_busy", 32'(busy), 32'h0);

`ifdef TRIGGER_OUTPUT_MISS_CNT_EN
    // Miss counter: three dropped edges in one busy window
    miss_clr = 1'b1;
    tick();
    miss_clr = 1'b0;
    check("miss_clr0", 32'(miss_cnt), 32'd0);
    trig_sel = 8'h01;
    width    = 16'd1;
    holdoff  = 16'd10;
    trig_req = 1'b1;
    tick();
    for (int k = 1; k <= 6; k++) begin
      trig_req = ~trig_req;
      tick();
    end
    trig_req = 1'b0;
    ticks(10);
    check("miss_three", 32'(miss_cnt), 32'd3);
    // Clear together with a dropped edge
    trig_req = 1'b1;
    tick();
    trig_req = 1'b0;
    tick();
    trig_req = 1'b1;
    miss_clr = 1'b1;
    tick();
    miss_clr = 1'b0;
    trig_req = 1'b0;
    check("miss_clr_wins", 32'(miss_cnt), 32'd0);
    ticks(14);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/trigger_output.md
Name: trigger_output

Overview:
- Trigger generator: converts one trigger request event into a timed pulse on a selectable set of R output lines.
- Programmable delay, width, holdoff and per-line polarity.
- Drives trigger lines out of the lock core, e.g. to the DIO/expansion pins or a scope trigger. It is the output-side counterpart of the edge-detecting trigger input stage.
- Request source is a tick from the lock logic or a software strobe.

Parameters:
- R, 8, number of trigger output lines.
- DW, 16, width of the delay, width and holdoff counters and their config inputs.

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- trig_req  in  1  trigger request; rising edge (0→1 between consecutive samples) starts a sequence.
- trig_sel  in  R  line enable mask; latched at accept.
- trig_pol  in  R  per-line idle level; active level is the inverse. Followed live in IDLE, latched at accept.
- delay  in  DW  cycles from accept to first active cycle, minus 1; latched at accept.
- width  in  DW  active cycles; 0 is treated as 1; latched at accept.
- holdoff  in  DW  dead cycles after pulse; latched at accept.
- trig_out  out  R  registered trigger lines.
- busy  out  1  high whenever state ≠ IDLE.
- done  out  1  1-cycle tick in the last active cycle.

Behaviour:
- Reset (async, rstn=0):
  - State = IDLE; counter = 0; latched config = 0.
  - trig_out = 0, busy = 0, done = 0, immediately.
  - Edge-detect history register = 1, so a trig_req held high through reset release does not fire until it is seen low first.
- Reset mid-sequence: abort at once with the values above; no completion tick.
- FSM states: IDLE, DELAY, PULSE, HOLD.
- IDLE:
  - Accept when trig_req=1 and the previous sample was 0.
  - On accept, latch sel/pol/delay/width/holdoff.
  - Next state is PULSE if delay=0, else DELAY.
- DELAY: count delay cycles, then go to PULSE.
- PULSE:
  - Count max(width,1) cycles.
  - On the last cycle assert done.
  - Next state is HOLD if holdoff≠0, else IDLE.
- HOLD: count holdoff cycles, then go to IDLE.
- Timing, with trig_req first sampled high at cycle t:
  - trig_out active in cycles t+1+delay … t+delay+max(width,1).
  - busy high from t+1 through the last HOLD cycle.
- Output encoding:
  - trig_out[i] = pol[i] XOR (in_pulse AND sel[i]), registered.
  - pol is live trig_pol in IDLE and the latched copy otherwise.
  - Unselected lines sit at their polarity level.
- Request handling outside IDLE:
  - Rising edges while state ≠ IDLE (including the final HOLD/PULSE cycle) are dropped, not queued.
  - A request is seen only if its edge is sampled while in IDLE.
  - A new edge in the first IDLE cycle is accepted: back-to-back period = delay+width+holdoff+1 minimum.
- Counters:
  - Unsigned, DW bits, compared against the latched value; no wrap.
  - Maximum values (2^DW−1) are legal and give the full count.
- Config changes mid-sequence have no effect until the next accept.

Optional Feature:
- Macro: TRIGGER_OUTPUT_MISS_CNT_EN.
- When defined:
  - Adds output miss_cnt (16 bits) and input miss_clr (1 bit).
  - miss_cnt increments on every trig_req rising edge dropped because state ≠ IDLE.
  - miss_cnt saturates at 0xFFFF.
  - miss_clr=1 zeroes it; clear wins over a simultaneous increment.
  - Reset value 0.
- When undefined: neither port exists and there is no counter logic.

Decomposition:
- Package trigger_pkg:
  - state encoding constants IDLE=2'd0, DELAY=2'd1, PULSE=2'd2, HOLD=2'd3;
  - default R/DW constants;
  - miss counter width (16).
- One sub-module, trigger_edge_det:
  - registered rising-edge detector with async active-low reset;
  - history reset to 1;
  - reusable by other trigger blocks.

Test Plan:
- Basic: R=8, sel=0x05, pol=0x00, delay=0, width=4, holdoff=0, single-cycle trig_req at t=10 → trig_out=0x05 in cycles 11–14, done at 14, busy 11–14, 0x00 after.
- Delay and polarity:
  - delay=3, width=2, pol=0xFF, sel=0x01, request at t=20 → trig_out=0xFE in cycles 24–25 and 0xFF otherwise.
  - With pol changed to 0x00 at t=22, output is still 0xFE/0xFF until the sequence ends.
- Width 0 and holdoff:
  - width=0, holdoff=5, request at t=0 → one active cycle at t=1.
  - busy through t=6.
  - Second edge at t=4 ignored; edge at t=7 accepted, active at t=8.
- Level hold: trig_req held high 50 cycles → exactly one sequence; a second sequence fires only after trig_req goes 0 then 1.
- Reset: assert rstn=0 during PULSE → trig_out=0, busy=0 the same cycle without waiting for clk; trig_req high at release does not fire.
- With TRIGGER_OUTPUT_MISS_CNT_EN defined:
  - 3 edges during one busy window → miss_cnt=3.
  - miss_clr together with a dropped edge → miss_cnt=0.
  - Preload to 0xFFFF plus a dropped edge → stays 0xFFFF.
